// File: rtl/mems_spi_arbiter_pkg.sv
// Shared types and constants for the MEMS DAC SPI arbiter.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-break.
package mems_spi_arbiter_pkg;

  localparam int DATA_W_DEF = 24;

  localparam logic PORT_SCAN = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GRANT     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mems_spi_arbiter_if.sv
// Requester/SPI-master bundle for the arbiter.
// slave = arbiter side, master = requesters and SPI master side.
interface mems_spi_arbiter_if
  import mems_spi_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0;
  logic [DATA_W-1:0] data0;
  logic              lock0;
  logic              ack0;
  logic              done0;

  logic              req1;
  logic [DATA_W-1:0] data1;
  logic              ack1;
  logic              done1;

  logic              spi_busy;
  logic              spi_start;
  logic [DATA_W-1:0] spi_data;
  logic              owner;
  logic              timeout_err;

  modport slave (
    input  req0, data0, lock0,
    input  req1, data1,
    input  spi_busy,
    output ack0, done0,
    output ack1, done1,
    output spi_start, spi_data,
    output owner, timeout_err
  );

  modport master (
    output req0, data0, lock0,
    output req1, data1,
    output spi_busy,
    input  ack0, done0,
    input  ack1, done1,
    input  spi_start, spi_data,
    input  owner, timeout_err
  );

endinterface

// File: rtl/mems_spi_arb_pick.sv
// Combinational winner select between scan and host ports.
// Build option: ARB_ROUND_ROBIN_EN (tie goes to port not granted last).
module mems_spi_arb_pick
  import mems_spi_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic lock_hold_i,
  input  logic owner_i,
  output logic win_vld_o,
  output logic win_port_o
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic tie_port;
  logic both;

  assign tie_port = RR_EN ? ~owner_i : PORT_SCAN;
  assign both     = req0_i & req1_i;

  always_comb begin
    win_vld_o  = req0_i | (req1_i & ~lock_hold_i);
    win_port_o = PORT_SCAN;
    unique case (1'b1)
      lock_hold_i:
        win_port_o = PORT_SCAN;
      (~lock_hold_i & both):
        win_port_o = tie_port;
      (~lock_hold_i & req1_i & ~req0_i):
        win_port_o = PORT_HOST;
      default:
        win_port_o = PORT_SCAN;
    endcase
  end

endmodule

// File: rtl/mems_spi_arbiter.sv
// Two-port arbiter in front of the 24-bit MEMS DAC SPI master.
// Build option: ARB_ROUND_ROBIN_EN (see mems_spi_arb_pick).
module mems_spi_arbiter
  import mems_spi_arbiter_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  mems_spi_arbiter_if.slave bus
);

  localparam logic [7:0] TO_LAST = 8'(BUSY_TIMEOUT - 1);
  localparam logic [7:0] TO_SAT  = 8'(BUSY_TIMEOUT);

  arb_state_e        state_q;
  logic [DATA_W-1:0] spi_data_q;
  logic              owner_q;
  logic              lock_q;
  logic              err_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic              ack0_q;
  logic              ack1_q;
  logic              done0_q;
  logic              done1_q;
  logic              start_q;

  logic lock_eff;
  logic win_vld;
  logic win_port;

  // Lock only binds while lock0 is still asserted this cycle.
  assign lock_eff = lock_q & bus.lock0;
  assign cnt_d    = cnt_q + 8'd1;

  mems_spi_arb_pick u_pick (
    .req0_i      (bus.req0),
    .req1_i      (bus.req1),
    .lock_hold_i (lock_eff),
    .owner_i     (owner_q),
    .win_vld_o   (win_vld),
    .win_port_o  (win_port)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      spi_data_q <= '0;
      owner_q    <= PORT_SCAN;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!bus.lock0) lock_q <= 1'b0;
          if (win_vld) begin
            owner_q <= win_port;
            state_q <= S_GRANT;
            if (win_port == PORT_SCAN) begin
              spi_data_q <= bus.data0;
              ack0_q     <= 1'b1;
              lock_q     <= bus.lock0;
            end else begin
              spi_data_q <= bus.data1;
              ack1_q     <= 1'b1;
            end
          end
        end
        S_GRANT: begin
          if (!bus.spi_busy) begin
            start_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (bus.spi_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_q >= TO_LAST) begin
            // Master never answered: report and release the bus.
            cnt_q   <= TO_SAT;
            err_q   <= 1'b1;
            done0_q <= (owner_q == PORT_SCAN);
            done1_q <= (owner_q == PORT_HOST);
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.spi_busy) begin
            done0_q <= (owner_q == PORT_SCAN);
            done1_q <= (owner_q == PORT_HOST);
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.spi_start   = start_q;
  assign bus.spi_data    = spi_data_q;
  assign bus.owner       = owner_q;
  assign bus.timeout_err = err_q;

endmodule
